// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline chain: DEPTH register stages with stall back-pressure,
// per-stage flush, bubble insertion and valid tracking, plus a saturating idle counter.
module ctrl_pipe_chain #(
    parameter int               WIDTH         = 3,
    parameter int               DEPTH         = 2,
    parameter logic [WIDTH-1:0] BUBBLE_VAL    = '0,
    parameter bit               SCRUB_INVALID = 1'b1,
    parameter int               CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       ctrl_in,
    input  logic                   valid_in,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic                   ready_out,
    output logic [DEPTH*WIDTH-1:0] ctrl_out,
    output logic [DEPTH-1:0]       valid_out,
    output logic [WIDTH-1:0]       ctrl_last,
    output logic                   valid_last,
    output logic [CNT_W-1:0]       bubble_count
);

    logic [DEPTH*WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DEPTH-1:0]       hold;

    // A stall anywhere downstream freezes every upstream stage.
    always_comb begin
        hold = '0;
        hold[DEPTH-1] = stall[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;

        if (flush[0]) begin
            ctrl_d[WIDTH-1:0] = BUBBLE_VAL;
            valid_d[0]        = 1'b0;
        end else if (!hold[0]) begin
            if (SCRUB_INVALID && !valid_in) begin
                ctrl_d[WIDTH-1:0] = BUBBLE_VAL;
            end else begin
                ctrl_d[WIDTH-1:0] = ctrl_in;
            end
            valid_d[0] = valid_in;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (flush[i]) begin
                ctrl_d[i*WIDTH +: WIDTH] = BUBBLE_VAL;
                valid_d[i]               = 1'b0;
            end else if (!hold[i]) begin
                // Upstream frozen while this stage drains: fill the gap with a bubble.
                if (hold[i-1]) begin
                    ctrl_d[i*WIDTH +: WIDTH] = BUBBLE_VAL;
                    valid_d[i]               = 1'b0;
                end else begin
                    ctrl_d[i*WIDTH +: WIDTH] = ctrl_q[(i-1)*WIDTH +: WIDTH];
                    valid_d[i]               = valid_q[i-1];
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!valid_q[DEPTH-1] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= {DEPTH{BUBBLE_VAL}};
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_out    = ~hold[0];
    assign ctrl_out     = ctrl_q;
    assign valid_out    = valid_q;
    assign ctrl_last    = ctrl_q[(DEPTH-1)*WIDTH +: WIDTH];
    assign valid_last   = valid_q[DEPTH-1];
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: two configurations driven by directed and random
// traffic, compared each cycle against a per-entry array model of the pipeline.
module tb_ctrl_pipe_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] ctrl_in;
    logic       valid_in;
    logic [1:0] stall_a, flush_a;
    logic [2:0] stall_b, flush_b;

    logic        ready_a, valid_last_a;
    logic [5:0]  ctrl_out_a;
    logic [1:0]  valid_out_a;
    logic [2:0]  ctrl_last_a;
    logic [15:0] cnt_a;

    logic        ready_b, valid_last_b;
    logic [8:0]  ctrl_out_b;
    logic [2:0]  valid_out_b;
    logic [2:0]  ctrl_last_b;
    logic [1:0]  cnt_b;

    ctrl_pipe_chain #(.WIDTH(3), .DEPTH(2)) dut_a (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall_a), .flush(flush_a), .ready_out(ready_a),
        .ctrl_out(ctrl_out_a), .valid_out(valid_out_a), .ctrl_last(ctrl_last_a),
        .valid_last(valid_last_a), .bubble_count(cnt_a)
    );

    ctrl_pipe_chain #(.WIDTH(3), .DEPTH(3), .BUBBLE_VAL(3'b010),
                      .SCRUB_INVALID(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall_b), .flush(flush_b), .ready_out(ready_b),
        .ctrl_out(ctrl_out_b), .valid_out(valid_out_b), .ctrl_last(ctrl_last_b),
        .valid_last(valid_last_b), .bubble_count(cnt_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] m_ctrl  [2][8];
    logic       m_valid [2][8];
    int         m_cnt   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock edge of the pipeline, as a list of {ctrl,valid} entries.
    // Stages are visited last-to-first so each one still sees its predecessor's old entry.
    task automatic model_step(input int k, input int depth, input bit scrub,
                              input logic [2:0] bval, input int cmax,
                              input logic [7:0] st, input logic [7:0] fl,
                              input logic rst, input logic [2:0] cin, input logic vin);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_ctrl[k][i]  = bval;
                m_valid[k][i] = 1'b0;
            end
            m_cnt[k] = 0;
            return;
        end
        if (!m_valid[k][depth-1] && m_cnt[k] < cmax) m_cnt[k]++;
        for (int i = depth - 1; i >= 0; i--) begin
            bit frozen, up_frozen;
            frozen    = ((st >> i) != 8'd0);
            up_frozen = (i > 0) && ((st >> (i - 1)) != 8'd0);
            if (fl[i]) begin
                m_ctrl[k][i] = bval; m_valid[k][i] = 1'b0;
            end else if (frozen) begin
                // entry stays where it is
            end else if (i == 0) begin
                m_ctrl[k][0]  = (scrub && !vin) ? bval : cin;
                m_valid[k][0] = vin;
            end else if (up_frozen) begin
                m_ctrl[k][i] = bval; m_valid[k][i] = 1'b0;
            end else begin
                m_ctrl[k][i]  = m_ctrl[k][i-1];
                m_valid[k][i] = m_valid[k][i-1];
            end
        end
    endtask

    task automatic check_outputs();
        logic [8:0] ec;
        logic [2:0] ev;
        ec = '0; ev = '0;
        for (int i = 0; i < 2; i++) begin ec[i*3 +: 3] = m_ctrl[0][i]; ev[i] = m_valid[0][i]; end
        chk("ctrl_out_a",  {26'd0, ctrl_out_a},   {23'd0, ec});
        chk("valid_out_a", {30'd0, valid_out_a},  {29'd0, ev});
        chk("ctrl_last_a", {29'd0, ctrl_last_a},  {29'd0, m_ctrl[0][1]});
        chk("valid_last_a",{31'd0, valid_last_a}, {31'd0, m_valid[0][1]});
        chk("count_a",     {16'd0, cnt_a},        m_cnt[0]);
        ec = '0; ev = '0;
        for (int i = 0; i < 3; i++) begin ec[i*3 +: 3] = m_ctrl[1][i]; ev[i] = m_valid[1][i]; end
        chk("ctrl_out_b",  {23'd0, ctrl_out_b},   {23'd0, ec});
        chk("valid_out_b", {29'd0, valid_out_b},  {29'd0, ev});
        chk("ctrl_last_b", {29'd0, ctrl_last_b},  {29'd0, m_ctrl[1][2]});
        chk("valid_last_b",{31'd0, valid_last_b}, {31'd0, m_valid[1][2]});
        chk("count_b",     {30'd0, cnt_b},        m_cnt[1]);
    endtask

    task automatic cycle(input logic r, input logic [2:0] c, input logic v,
                         input logic [1:0] sa, input logic [1:0] fa,
                         input logic [2:0] sb, input logic [2:0] fb);
        reset = r; ctrl_in = c; valid_in = v;
        stall_a = sa; flush_a = fa; stall_b = sb; flush_b = fb;
        #1;
        chk("ready_a", {31'd0, ready_a}, {31'd0, (sa == 2'b00)});
        chk("ready_b", {31'd0, ready_b}, {31'd0, (sb == 3'b000)});
        @(posedge clk);
        model_step(0, 2, 1'b1, 3'b000, 65535, {6'd0, sa}, {6'd0, fa}, r, c, v);
        model_step(1, 3, 1'b0, 3'b010, 3,     {5'd0, sb}, {5'd0, fb}, r, c, v);
        #1;
        check_outputs();
    endtask

    initial begin
        cycle(1'b1, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000, 3'b000);
        chk("rst_valid_a", {30'd0, valid_out_a}, 32'd0);
        chk("rst_count_a", {16'd0, cnt_a}, 32'd0);

        // Plain stream: 101, 011, 110 emerge two cycles after capture.
        cycle(1'b0, 3'b101, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        cycle(1'b0, 3'b011, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        chk("stream_1st", {29'd0, ctrl_last_a}, 32'h5);
        chk("stream_vld", {31'd0, valid_last_a}, 32'h1);
        cycle(1'b0, 3'b110, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        chk("stream_2nd", {29'd0, ctrl_last_a}, 32'h3);
        cycle(1'b0, 3'b011, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        chk("stream_3rd", {29'd0, ctrl_last_a}, 32'h6);

        // A=101 in stage 0, B=011 in stage 1, then stall stage 0 twice.
        cycle(1'b0, 3'b101, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        cycle(1'b0, 3'b111, 1'b1, 2'b01, 2'b00, 3'b001, 3'b000);
        cycle(1'b0, 3'b111, 1'b1, 2'b01, 2'b00, 3'b001, 3'b000);
        chk("stall0_bub", {30'd0, valid_out_a}, 32'h1);
        chk("stall0_hold", {29'd0, ctrl_out_a[2:0]}, 32'h5);
        cycle(1'b0, 3'b111, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        chk("stall0_rel", {29'd0, ctrl_last_a}, 32'h5);

        // Stall the last stage for one cycle, then flush+stall it together.
        cycle(1'b0, 3'b110, 1'b1, 2'b10, 2'b00, 3'b100, 3'b000);
        cycle(1'b0, 3'b110, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        cycle(1'b0, 3'b001, 1'b1, 2'b10, 2'b10, 3'b100, 3'b100);
        chk("flush_stall", {30'd0, valid_out_a}, 32'h1);
        cycle(1'b0, 3'b001, 1'b1, 2'b10, 2'b00, 3'b100, 3'b000);

        // Invalid input: scrubbed in dut_a, kept in dut_b.
        cycle(1'b0, 3'b111, 1'b0, 2'b00, 2'b00, 3'b000, 3'b000);
        chk("scrub_a", {29'd0, ctrl_out_a[2:0]}, 32'h0);
        chk("noscrub_b", {29'd0, ctrl_out_b[2:0]}, 32'h7);

        // Reset during stall and flush, then idle to saturate the 2-bit counter.
        cycle(1'b0, 3'b100, 1'b1, 2'b00, 2'b00, 3'b000, 3'b000);
        cycle(1'b1, 3'b100, 1'b1, 2'b11, 2'b01, 3'b111, 3'b001);
        chk("rst_mid_b", {23'd0, ctrl_out_b}, 32'h092);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000, 3'b000);
        chk("sat_b", {30'd0, cnt_b}, 32'h3);
        chk("idle_a", {16'd0, cnt_a}, 32'h5);

        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic [2:0] c;
            logic       v;
            logic [1:0] sa, fa;
            logic [2:0] sb, fb;
            r  = ($urandom_range(0, 59) == 0);
            c  = 3'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            sa = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            fa = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            sb = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            fb = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            cycle(r, c, v, sa, fa, sb, fb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
- Parametrised chain of control-signal pipeline registers; generalises the single fixed M->W control register.
- Carries a WIDTH-bit control bundle through DEPTH stages, with per-stage stall, per-stage flush, bubble insertion and per-stage valid tracking.
- Sits between the decode-side control unit and the back-end stages; instantiated once per control bundle, e.g. {RegWrite, ResultSrc[1:0]}.

Parameters:
- WIDTH, 3, control bundle width in bits.
- DEPTH, 2, number of register stages; legal range 1..8.
- BUBBLE_VAL, '0, WIDTH-bit value loaded on reset, flush or bubble; must deassert all architectural side effects.
- SCRUB_INVALID, 1, if 1 an entry with valid_in=0 is captured as BUBBLE_VAL instead of ctrl_in.
- CNT_W, 16, width of bubble_count.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- ctrl_in  in  WIDTH  control bundle entering stage 0.
- valid_in  in  1  ctrl_in is a real instruction.
- stall  in  DEPTH  stall[i] holds stage i.
- flush  in  DEPTH  flush[i] clears stage i.
- ready_out  out  1  stage 0 accepts ctrl_in this cycle (= ~hold[0]).
- ctrl_out  out  DEPTH*WIDTH  stage i contents at bits [i*WIDTH +: WIDTH].
- valid_out  out  DEPTH  valid bit per stage.
- ctrl_last  out  WIDTH  alias of stage DEPTH-1 contents.
- valid_last  out  1  alias of valid_out[DEPTH-1].
- bubble_count  out  CNT_W  cycles since reset with valid_last=0, saturating.

Behaviour:
- Reset: synchronous and active-high; one clock with reset=1 sets every stage to BUBBLE_VAL with valid=0, and bubble_count to 0. Reset overrides stall and flush. All outputs are registered or aliases of registers; no combinational path from inputs to ctrl_out or valid_out.
- Hold chain (combinational):
  - hold[DEPTH-1] = stall[DEPTH-1].
  - hold[i] = stall[i] | hold[i+1] for i < DEPTH-1.
  - A stall backs up into every upstream stage.
- Per-stage update at posedge, in priority order:
  1. flush[i]: stage <= BUBBLE_VAL, valid <= 0.
  2. hold[i]: stage keeps its value.
  3. i=0: load ctrl_in and valid_in. If SCRUB_INVALID=1 and valid_in=0, load BUBBLE_VAL instead.
  4. i>0 and hold[i-1]=1: stage i-1 is stalled while stage i advances, so insert a bubble (BUBBLE_VAL, valid 0).
  5. Otherwise: stage i <= stage i-1, including its valid bit.
- Latency: ctrl_in appears on ctrl_last exactly DEPTH cycles after capture when no stall or flush occurs. Throughput is one entry per cycle.
- Flush beats stall on the same stage. A flushed stage that is also held comes out as a bubble and then holds the bubble.
- Flush of stage i has no effect on stages j != i in that cycle.
- ready_out=0: the producer must hold ctrl_in/valid_in. The block drops nothing because stage 0 holds, not loads.
- DEPTH=1: hold[0]=stall[0]; rule 4 never applies.
- bubble_count:
  - Increments each non-reset cycle in which valid_last=0 (the value before the edge).
  - Saturates at 2^CNT_W-1 with no wrap.
  - Does not increment during reset.
- Reset asserted mid-stall or mid-flush: the next cycle shows the reset state only.

Test Plan (WIDTH=3, DEPTH=2, BUBBLE_VAL=0 unless noted):
1. Reset, then stream ctrl_in=3'b101,3'b011,3'b110 with valid_in=1, no stall -> ctrl_last shows 101,011,110 on cycles 2,3,4 after the first capture; valid_last=1 on those cycles; ready_out=1 throughout.
2. Pipe holds A=101 in stage 0 and B=011 in stage 1; assert stall[0] for 2 cycles -> stage 1 gets B and then bubble 000/valid 0; stage 0 holds A; ready_out=0; A reaches stage 1 one cycle after stall drops.
3. Assert stall[1] for 1 cycle with both stages valid -> both stages hold, no bubble, ready_out=0; flow resumes with no loss or duplication.
4. Assert flush[1] and stall[1] in the same cycle with stage 1=110 valid -> stage 1 becomes 000/valid 0 and stays; stage 0 is unchanged.
5. Set valid_in=0 with ctrl_in=3'b111, SCRUB_INVALID=1 -> stage 0 captures 000/valid 0. Repeat with SCRUB_INVALID=0 -> captures 111/valid 0.
6. Assert reset while stall=2'b11 and flush=2'b01 with stages holding data -> next cycle all stages 000, valid_out=0, bubble_count=0. With CNT_W=2, idle 5 cycles -> bubble_count saturates at 3.
